// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared state encoding and width helpers for the PLL lock sequencer
package pll_seq_pkg;
    typedef enum logic [2:0] {RESET_PLL, WAIT_LOCK, HOLD, ENABLE, RUN, FAIL} state_t;
    localparam int LOSS_W = 8;
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        m = (m > d) ? m : d;
        return (m < 2) ? 1 : $clog2(m);
    endfunction
    function automatic int retry_width(input int r);
        return (r < 1) ? 1 : $clog2(r + 1);
    endfunction
endpackage

// File: rtl/lock_sync.sv
// lock_sync: per-bit two-flop synchroniser for the asynchronous PLL lock inputs
module lock_sync #(
    parameter int CHANNELS = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] i_async,
    output logic [CHANNELS-1:0] o_sync
);
    logic [CHANNELS-1:0] r_meta, r_sync;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end
    assign o_sync = r_sync;
endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: resets PLLs, qualifies lock, staggers clock enables, then releases system reset
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int CHANNELS         = 2,
    parameter int RST_PULSE_CYCLES = 16,
    parameter int HOLD_CYCLES      = 1024,
    parameter int STAGGER_CYCLES   = 64,
    parameter int TIMEOUT_CYCLES   = 65536,
    parameter int MAX_RETRIES      = 3
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [CHANNELS-1:0]                 pllLocked,
    output logic                                pllReset,
    output logic [CHANNELS-1:0]                 clkEnable,
    output logic                                sysReset,
    output logic                                isLocked,
    output logic                                failed,
    output logic [retry_width(MAX_RETRIES)-1:0] retryCount,
    output logic [LOSS_W-1:0]                   lossCount
);
    localparam int CW = cnt_width(TIMEOUT_CYCLES, HOLD_CYCLES, STAGGER_CYCLES, RST_PULSE_CYCLES);
    localparam int RW = retry_width(MAX_RETRIES);
    localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CW-1:0] C_RST  = CW'(RST_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] C_TO   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] C_HOLD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] C_STG  = CW'(STAGGER_CYCLES - 1);
    localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRIES);
    localparam logic [SW-1:0] S_LAST = SW'(CHANNELS - 1);

    state_t                r_state, w_state_nxt;
    logic [CW-1:0]         r_cnt, w_cnt_nxt;
    logic [SW-1:0]         r_stage, w_stage_nxt;
    logic                  w_bump, w_all, w_loss_ev;
    logic [CHANNELS-1:0]   w_sync, w_therm, w_en_nxt;
    logic                  r_pr, r_sys, r_lk, r_fail;
    logic [CHANNELS-1:0]   r_en;
    logic [RW-1:0]         r_retry, w_retry_nxt;
    logic [LOSS_W-1:0]     r_loss, w_loss_nxt;

    lock_sync #(.CHANNELS(CHANNELS)) u_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (pllLocked),
        .o_sync  (w_sync)
    );
    assign w_all = &w_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RESET_PLL;
            r_cnt   <= '0;
            r_stage <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_stage <= w_stage_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bump      = 1'b0;
        case (r_state)
            RESET_PLL: w_state_nxt = (r_cnt == C_RST) ? WAIT_LOCK : RESET_PLL;
            WAIT_LOCK: w_state_nxt = w_all ? HOLD : (r_cnt != C_TO) ? WAIT_LOCK :
                                     (r_retry == R_MAX) ? FAIL : RESET_PLL;
            HOLD:      w_state_nxt = !w_all ? WAIT_LOCK : (r_cnt == C_HOLD) ? ENABLE : HOLD;
            ENABLE: begin
                w_bump      = w_all && (r_cnt == C_STG);
                w_state_nxt = !w_all ? RESET_PLL : (w_bump && r_stage == S_LAST) ? RUN : ENABLE;
            end
            RUN:       w_state_nxt = w_all ? RUN : RESET_PLL;
            default:   w_state_nxt = FAIL;
        endcase
        w_stage_nxt = (w_state_nxt != ENABLE) ? '0 : w_bump ? r_stage + 1'b1 : r_stage;
        w_cnt_nxt   = (w_state_nxt != r_state || w_bump) ? '0 : r_cnt + 1'b1;
    end

    // Outputs are decoded from the state being entered so they switch on the same edge
    always_comb begin
        w_therm     = ~({CHANNELS{1'b1}} << (32'(w_stage_nxt) + 1));
        w_en_nxt    = (w_state_nxt == RUN) ? '1 : (w_state_nxt == ENABLE) ? w_therm : '0;
        w_loss_ev   = (r_state == ENABLE || r_state == RUN) && w_state_nxt == RESET_PLL;
        w_loss_nxt  = (w_loss_ev && r_loss != '1) ? r_loss + 1'b1 : r_loss;
        w_retry_nxt = (w_state_nxt == RUN) ? '0 :
                      (r_state == WAIT_LOCK && w_state_nxt == RESET_PLL) ? r_retry + 1'b1 : r_retry;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pr    <= 1'b1;
            r_en    <= '0;
            r_sys   <= 1'b1;
            r_lk    <= 1'b0;
            r_fail  <= 1'b0;
            r_retry <= '0;
            r_loss  <= '0;
        end else begin
            r_pr    <= w_state_nxt == RESET_PLL || w_state_nxt == FAIL;
            r_en    <= w_en_nxt;
            r_sys   <= w_state_nxt != RUN;
            r_lk    <= w_state_nxt == RUN;
            r_fail  <= w_state_nxt == FAIL;
            r_retry <= w_retry_nxt;
            r_loss  <= w_loss_nxt;
        end
    end

    assign pllReset   = r_pr;
    assign clkEnable  = r_en;
    assign sysReset   = r_sys;
    assign isLocked   = r_lk;
    assign failed     = r_fail;
    assign retryCount = r_retry;
    assign lossCount  = r_loss;
endmodule
